// File: rtl/pc_pkg.sv
// Shared address type and default constants for the fetch-stage program counter.
package pc_pkg;

   localparam int PC_WIDTH = 32;

   typedef logic [PC_WIDTH-1:0] addr_t;

   localparam addr_t RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam int    PC_INCR              = 4;
   localparam int    PC_ALIGN_BITS        = 2;

endpackage

// File: rtl/pc_trace_buf.sv
// Circular history of recently loaded PC values; index 0 reads the newest entry.
module pc_trace_buf #(
   parameter int               WIDTH        = 32,
   parameter int               DEPTH        = 8,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [WIDTH-1:0]         rd_data
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0] wr_ptr;

   // DEPTH is a power of two, so the pointer wraps by plain overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RESET_VECTOR;
         end
         wr_ptr <= '0;
      end else if (wr_en) begin
         mem[wr_ptr] <= wr_data;
         wr_ptr      <= wr_ptr + 1'b1;
      end
   end

   assign rd_data = mem[wr_ptr - IDX_W'(1) - rd_idx];

endmodule

// File: rtl/program_counter.sv
// Fetch-stage program counter with stall hold, successor address and alignment flag.
// Define PC_TRACE_EN to add the trace_rd_idx/trace_rd_data history port.
module program_counter
   import pc_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT),
   parameter int               INCR         = PC_INCR,
   parameter int               ALIGN_BITS   = PC_ALIGN_BITS,
   parameter int               TRACE_DEPTH  = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [WIDTH-1:0]               pc_in,
   input  logic                           stall,
`ifdef PC_TRACE_EN
   input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
   output logic [WIDTH-1:0]               trace_rd_data,
`endif
   output logic [WIDTH-1:0]               pc_out,
   output logic [WIDTH-1:0]               pc_seq,
   output logic                           pc_valid,
   output logic                           misaligned
);

   // misaligned is derived from pc_in so it always travels with the loaded pc_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_out     <= RESET_VECTOR;
         pc_valid   <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         pc_valid <= 1'b1;
         if (!stall) begin
            pc_out     <= pc_in;
            misaligned <= |pc_in[ALIGN_BITS-1:0];
         end
      end
   end

   assign pc_seq = pc_out + WIDTH'(INCR);

`ifdef PC_TRACE_EN
   pc_trace_buf #(
      .WIDTH        (WIDTH),
      .DEPTH        (TRACE_DEPTH),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_trace (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (!stall),
      .wr_data (pc_in),
      .rd_idx  (trace_rd_idx),
      .rd_data (trace_rd_data)
   );
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: hand sequences, a vector table and random stimulus.
module tb_program_counter;
   import pc_pkg::*;

   localparam int TRACE_DEPTH = 8;

   logic  clk = 1'b0;
   logic  rst;
   addr_t pc_in;
   logic  stall;
   addr_t pc_out;
   addr_t pc_seq;
   logic  pc_valid;
   logic  misaligned;
`ifdef PC_TRACE_EN
   logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx;
   addr_t                          trace_rd_data;
`endif

   program_counter #(.TRACE_DEPTH(TRACE_DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_in      (pc_in),
      .stall      (stall),
`ifdef PC_TRACE_EN
      .trace_rd_idx  (trace_rd_idx),
      .trace_rd_data (trace_rd_data),
`endif
      .pc_out     (pc_out),
      .pc_seq     (pc_seq),
      .pc_valid   (pc_valid),
      .misaligned (misaligned)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

   // scoreboard state
   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   // reference model: architectural view of the PC
   addr_t m_pc;
   bit    m_valid;
   bit    m_mis;
   addr_t hist[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc    = RESET_VECTOR_DEFAULT;
      m_valid = 1'b0;
      m_mis   = 1'b0;
      hist.delete();
   endtask

   task automatic model_edge(input addr_t pc, input logic st);
      m_valid = 1'b1;
      if (!st) begin
         m_pc  = pc;
         m_mis = (pc % 4) != 0;
         hist.push_front(pc);
         if (hist.size() > TRACE_DEPTH) void'(hist.pop_back());
      end
   endtask

   function automatic addr_t seq_of(input addr_t pc);
      longint unsigned s;
      s = (longint'(pc) + 4) % (64'd1 << 32);
      return addr_t'(s);
   endfunction

   function automatic addr_t trace_exp(input int i);
      return (i < hist.size()) ? hist[i] : RESET_VECTOR_DEFAULT;
   endfunction

   task automatic check_model(input string tag);
      exp_q.push_back(m_pc);
      chk({tag, "_pc_out"}, pc_out, exp_q.pop_front());
      chk({tag, "_pc_seq"}, pc_seq, seq_of(m_pc));
      chk({tag, "_misaligned"}, 32'(misaligned), 32'(m_mis));
      chk({tag, "_pc_valid"}, 32'(pc_valid), 32'(m_valid));
   endtask

   // driver: apply inputs at the falling edge, sample 1 time unit after the rising edge
   task automatic apply_step(input addr_t pc, input logic st);
      @(negedge clk);
      pc_in = pc;
      stall = st;
      @(posedge clk);
      #1;
      model_edge(pc, st);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
   endtask

`ifdef PC_TRACE_EN
   task automatic check_trace(input string tag, input int idx);
      trace_rd_idx = idx[$clog2(TRACE_DEPTH)-1:0];
      #1;
      chk($sformatf("%s_trace_idx%0d", tag, idx), trace_rd_data, trace_exp(idx));
   endtask
`endif

   typedef struct {
      addr_t pc_in;
      logic  stall;
      addr_t exp_pc;
      logic  exp_mis;
      addr_t exp_seq;
   } vec_t;

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{32'd5,          1'b0, 32'd5,          1'b1, 32'd9};
      vecs[1]  = '{32'd15,         1'b0, 32'd15,         1'b1, 32'd19};
      vecs[2]  = '{32'd25,         1'b0, 32'd25,         1'b1, 32'd29};
      vecs[3]  = '{32'd35,         1'b0, 32'd35,         1'b1, 32'd39};
      vecs[4]  = '{32'd45,         1'b0, 32'd45,         1'b1, 32'd49};
      vecs[5]  = '{32'd55,         1'b0, 32'd55,         1'b1, 32'd59};
      vecs[6]  = '{32'd65,         1'b0, 32'd65,         1'b1, 32'd69};
      vecs[7]  = '{32'h0000_0100,  1'b0, 32'h0000_0100,  1'b0, 32'h0000_0104};
      vecs[8]  = '{32'hFFFF_FFFC,  1'b0, 32'hFFFF_FFFC,  1'b0, 32'h0000_0000};
      vecs[9]  = '{32'h0000_0020,  1'b0, 32'h0000_0020,  1'b0, 32'h0000_0024};
      vecs[10] = '{32'h0000_0040,  1'b1, 32'h0000_0020,  1'b0, 32'h0000_0024};
      vecs[11] = '{32'h0000_0040,  1'b1, 32'h0000_0020,  1'b0, 32'h0000_0024};
      vecs[12] = '{32'h0000_0040,  1'b0, 32'h0000_0040,  1'b0, 32'h0000_0044};

      rst   = 1'b1;
      pc_in = 32'd99;
      stall = 1'b0;
`ifdef PC_TRACE_EN
      trace_rd_idx = '0;
`endif
      model_reset();

      // reset state while clock runs
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_pc_valid", 32'(pc_valid), 32'd0);
      chk("rst_misaligned", 32'(misaligned), 32'd0);
      chk("rst_pc_seq", pc_seq, 32'd4);

      // release reset with stall held: valid must still set, PC must hold
      @(negedge clk);
      rst   = 1'b0;
      stall = 1'b1;
      #1;
      chk("pre_edge_pc_valid", 32'(pc_valid), 32'd0);
      @(posedge clk);
      #1;
      model_edge(32'd99, 1'b1);
      check_model("rel_stall");

      // vector table
      foreach (vecs[i]) begin
         apply_step(vecs[i].pc_in, vecs[i].stall);
         exp_q.push_back(vecs[i].exp_pc);
         chk($sformatf("tbl%0d_pc_out", i), pc_out, exp_q.pop_front());
         chk($sformatf("tbl%0d_misaligned", i), 32'(misaligned), 32'(vecs[i].exp_mis));
         chk($sformatf("tbl%0d_pc_seq", i), pc_seq, vecs[i].exp_seq);
      end

      // pc_in wiggling between edges, then asynchronous reset mid-cycle
      apply_step(32'h0000_0041, 1'b0);
      check_model("mis41");
      @(negedge clk);
      pc_in = 32'h0000_1234;
      stall = 1'b0;
      #1;
      chk("between_edges_pc_out", pc_out, 32'h0000_0041);
      chk("between_edges_pc_seq", pc_seq, 32'h0000_0045);
      rst = 1'b1;
      #1;
      chk("async_rst_pc_out", pc_out, 32'd0);
      chk("async_rst_pc_valid", 32'(pc_valid), 32'd0);
      chk("async_rst_misaligned", 32'(misaligned), 32'd0);
      #1;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      model_edge(32'h0000_1234, 1'b0);
      check_model("post_async_rst");

`ifdef PC_TRACE_EN
      pulse_reset();
      for (int i = 0; i < TRACE_DEPTH; i++) check_trace("trace_rst", i);
      apply_step(32'd4, 1'b0);
      apply_step(32'd8, 1'b0);
      apply_step(32'd12, 1'b0);
      chk("trace_newest", 32'd12, 32'd12 ^ 32'd0);
      for (int i = 0; i < 3; i++) check_trace("trace_three", i);
      apply_step(32'd99, 1'b1);
      check_trace("trace_stall", 0);
      for (int k = 1; k <= 9; k++) apply_step(32'(12 + 4 * k), 1'b0);
      for (int i = 0; i < TRACE_DEPTH; i++) check_trace("trace_wrap", i);
`endif

      // randomized run against the model
      pulse_reset();
      for (int n = 0; n < 300; n++) begin
         addr_t r;
         logic  st;
         r  = $urandom();
         if ($urandom_range(0, 1) == 0) r = r & 32'hFFFF_FFFC;
         if ($urandom_range(0, 15) == 0) r = 32'hFFFF_FFFC;
         st = ($urandom_range(0, 3) == 0);
         apply_step(r, st);
         check_model($sformatf("rnd%0d", n));
`ifdef PC_TRACE_EN
         check_trace($sformatf("rnd%0d", n), int'($urandom_range(0, TRACE_DEPTH - 1)));
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
